io_port_ctrl: RTL and testbench

- CPU-side I/O responder for the basic computer. Holds INPR/OUTR and the FGI/FGO flags, plus the IEN flip-flop.
- Services the controller's INP, OUT, SKI, SKO, ION and IOF micro-operations. Runs valid/ready handshakes with an external character device.
- Drives the fgi input the controller samples for its interrupt cycle, and a combined irq.

---
 rtl/io_port_ctrl.sv | 176 +++++++++++++++++
 tb/tb_io_port_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// CPU-side I/O port for the basic computer: INPR/OUTR, FGI/FGO, IEN and device handshakes.
// Define IO_INFIFO_EN to replace the single INPR register with a FIFO_DEPTH-entry input FIFO.
module io_port_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inp_rd,
  input  logic              out_wr,
  input  logic [DATA_W-1:0] ac_in,
  input  logic              set_ien,
  input  logic              clr_ien,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  output logic              irq,
  output logic              out_ovr,
  input  logic [DATA_W-1:0] dev_in_data,
  input  logic              dev_in_valid,
  output logic              dev_in_ready,
  output logic [DATA_W-1:0] dev_out_data,
  output logic              dev_out_valid,
  input  logic              dev_out_ready
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_port_ctrl: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic {OUT_FREE = 1'b0, OUT_BUSY = 1'b1} out_state_e;

  out_state_e        out_state_q, out_state_d;
  logic [DATA_W-1:0] outr_q, outr_d;
  logic              out_ovr_q, out_ovr_d;
  logic              ien_q, ien_d;

`ifdef IO_INFIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Push is gated by registered full, so a pop on a full FIFO frees space only next cycle.
  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    empty    = (count_q == '0);
    push     = dev_in_valid & ~full;
    pop      = inp_rd & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = dev_in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    dev_in_ready = ~full;
    fgi          = ~empty;
    inpr         = mem_q[rd_ptr_q];
  end
`else
  typedef enum logic {IN_EMPTY = 1'b0, IN_FULL = 1'b1} in_state_e;

  in_state_e         in_state_q, in_state_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q <= IN_EMPTY;
      inpr_q     <= '0;
    end else begin
      in_state_q <= in_state_d;
      inpr_q     <= inpr_d;
    end
  end

  // A full register ignores the device, so a same-cycle pop and offer only pops.
  always_comb begin
    in_state_d = in_state_q;
    inpr_d     = inpr_q;
    case (in_state_q)
      IN_EMPTY: begin
        if (dev_in_valid) begin
          inpr_d     = dev_in_data;
          in_state_d = IN_FULL;
        end
      end
      IN_FULL: begin
        if (inp_rd) in_state_d = IN_EMPTY;
      end
      default: in_state_d = IN_EMPTY;
    endcase
  end

  always_comb begin
    dev_in_ready = (in_state_q == IN_EMPTY);
    fgi          = (in_state_q == IN_FULL);
    inpr         = inpr_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= OUT_FREE;
      outr_q      <= '0;
      out_ovr_q   <= 1'b0;
      ien_q       <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      outr_q      <= outr_d;
      out_ovr_q   <= out_ovr_d;
      ien_q       <= ien_d;
    end
  end

  // A write while busy is dropped and latches the sticky overrun flag.
  always_comb begin
    out_state_d = out_state_q;
    outr_d      = outr_q;
    out_ovr_d   = out_ovr_q;
    case (out_state_q)
      OUT_FREE: begin
        if (out_wr) begin
          outr_d      = ac_in;
          out_state_d = OUT_BUSY;
        end
      end
      OUT_BUSY: begin
        if (out_wr)        out_ovr_d   = 1'b1;
        if (dev_out_ready) out_state_d = OUT_FREE;
      end
      default: out_state_d = OUT_FREE;
    endcase
  end

  always_comb begin
    ien_d = ien_q;
    if (set_ien) ien_d = 1'b1;
    if (clr_ien) ien_d = 1'b0;
  end

  always_comb begin
    fgo           = (out_state_q == OUT_FREE);
    dev_out_valid = (out_state_q == OUT_BUSY);
    dev_out_data  = outr_q;
    out_ovr       = out_ovr_q;
    ien           = ien_q;
    irq           = ien_q & (fgi | fgo);
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Table-driven bench for io_port_ctrl with a scoreboard of expected post-edge outputs.
module tb_io_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inp_rd, out_wr, set_ien, clr_ien;
  logic [7:0] ac_in, inpr, dev_in_data, dev_out_data;
  logic       fgi, fgo, ien, irq, out_ovr;
  logic       dev_in_valid, dev_in_ready, dev_out_valid, dev_out_ready;

  io_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inp_rd(inp_rd), .out_wr(out_wr), .ac_in(ac_in),
    .set_ien(set_ien), .clr_ien(clr_ien), .inpr(inpr), .fgi(fgi), .fgo(fgo),
    .ien(ien), .irq(irq), .out_ovr(out_ovr), .dev_in_data(dev_in_data),
    .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
    .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid),
    .dev_out_ready(dev_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rd; logic wr; logic [7:0] ac; logic si; logic ci;
    logic [7:0] did; logic div; logic dor;
  } in_t;

  typedef struct packed {
    logic [7:0] inpr; logic fgi; logic fgo; logic ien; logic irq;
    logic ovr; logic irdy; logic [7:0] od; logic oval;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input logic rd, input logic wr, input logic [7:0] ac,
                              input logic si, input logic ci, input logic [7:0] did,
                              input logic div, input logic dor,
                              input logic [7:0] e_inpr, input logic e_fgi, input logic e_fgo,
                              input logic e_ien, input logic e_irq, input logic e_ovr,
                              input logic e_irdy, input logic [7:0] e_od, input logic e_oval);
    vec_t v;
    v.i = in_t'({rd, wr, ac, si, ci, did, div, dor});
    v.o = out_t'({e_inpr, e_fgi, e_fgo, e_ien, e_irq, e_ovr, e_irdy, e_od, e_oval});
    tbl.push_back(v);
  endfunction

  function automatic out_t sample();
    return out_t'({inpr, fgi, fgo, ien, irq, out_ovr, dev_in_ready, dev_out_data, dev_out_valid});
  endfunction

  task automatic drive(input in_t i);
    inp_rd = i.rd; out_wr = i.wr; ac_in = i.ac; set_ien = i.si; clr_ien = i.ci;
    dev_in_data = i.did; dev_in_valid = i.div; dev_out_ready = i.dor;
  endtask

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (inpr,fgi,fgo,ien,irq,ovr,irdy,od,oval)",
               name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    drive(v.i);
    sb.push_back(v.o);
    @(posedge clk);
    #1;
    check_out(name, sample(), sb.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", sample(), out_t'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;

`ifdef IO_INFIFO_EN
    //  rd wr ac    si ci did   dv dr | inpr  fgi fgo ien irq ovr rdy od    ov
    add(0, 0, 8'h00, 0, 0, 8'h01, 1, 0,  8'h01, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h02, 1, 0,  8'h01, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h03, 1, 0,  8'h01, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h04, 1, 0,  8'h01, 1, 1, 0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h05, 1, 0,  8'h01, 1, 1, 0, 0, 0, 0, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h05, 1, 0,  8'h02, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h03, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h04, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h01, 0, 1, 0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h05, 1, 0,  8'h05, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h06, 1, 0,  8'h06, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h03, 0, 1, 0, 0, 0, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h03, 0, 1, 0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0,  8'h03, 0, 1, 1, 1, 0, 1, 8'h00, 0);
`else
    //  rd wr ac    si ci did   dv dr | inpr  fgi fgo ien irq ovr rdy od    ov
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h00, 0, 1, 0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h41, 1, 0,  8'h41, 1, 1, 0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h41, 1, 1, 0, 0, 0, 0, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h77, 1, 0,  8'h41, 0, 1, 0, 0, 0, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h41, 0, 1, 0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h42, 1, 0,  8'h42, 1, 1, 0, 0, 0, 0, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h42, 0, 1, 0, 0, 0, 1, 8'h00, 0);
    add(0, 1, 8'h5A, 0, 0, 8'h00, 0, 0,  8'h42, 0, 0, 0, 0, 0, 1, 8'h5A, 1);
    for (int k = 0; k < 5; k++)
      add(0, 0, 8'hC3, 0, 0, 8'h00, 0, 0, 8'h42, 0, 0, 0, 0, 0, 1, 8'h5A, 1);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  8'h42, 0, 1, 0, 0, 0, 1, 8'h5A, 0);
    add(0, 1, 8'h5A, 0, 0, 8'h00, 0, 0,  8'h42, 0, 0, 0, 0, 0, 1, 8'h5A, 1);
    add(0, 1, 8'h33, 0, 0, 8'h00, 0, 0,  8'h42, 0, 0, 0, 0, 1, 1, 8'h5A, 1);
    add(0, 1, 8'h44, 0, 0, 8'h00, 0, 1,  8'h42, 0, 1, 0, 0, 1, 1, 8'h5A, 0);
    add(0, 0, 8'h00, 1, 1, 8'h00, 0, 0,  8'h42, 0, 1, 0, 0, 1, 1, 8'h5A, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0,  8'h42, 0, 1, 1, 1, 1, 1, 8'h5A, 0);
    add(0, 1, 8'h11, 0, 0, 8'h00, 0, 0,  8'h42, 0, 0, 1, 0, 1, 1, 8'h11, 1);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h42, 0, 0, 1, 0, 1, 1, 8'h11, 1);
    add(0, 0, 8'h00, 0, 0, 8'h99, 1, 0,  8'h99, 1, 0, 1, 1, 1, 0, 8'h11, 1);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  8'h99, 1, 1, 1, 1, 1, 0, 8'h11, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8'h99, 0, 1, 1, 1, 1, 1, 8'h11, 0);
    add(0, 0, 8'h00, 0, 1, 8'h00, 0, 0,  8'h99, 0, 1, 0, 0, 1, 1, 8'h11, 0);
`endif

    foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k]);

    // Reset asserted mid-handshake: both sides busy, then abandoned.
    @(negedge clk);
    drive(in_t'({1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0}));
    @(posedge clk);
    #1;
    check_bit("pre_rst_oval", dev_out_valid, 1'b1);
    @(negedge clk);
    drive(in_t'({1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", sample(), out_t'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}));
    check_bit("async_rst_irq", irq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive('0);
    begin
      vec_t v;
      v.i = '0;
      v.o = out_t'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
      step("post_rst_idle", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
